// File: rtl/bcd_down_timer_pkg.sv
// Shared types and constants for the two-digit BCD down timer.
package bcd_down_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_dn.sv
// One BCD digit: clamped load, decrement with 0 -> 9 wrap, and a borrow-out.
module bcd_digit_dn (
  input  logic       clk,
  input  logic       clr,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic [3:0] o_q,
  output logic       o_borrow
);
  import bcd_down_timer_pkg::*;

  logic [3:0] r_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_q <= BCD_ZERO;
    end else if (i_load) begin
      r_q <= bcd_clamp(i_load_val);
    end else if (i_dec) begin
      r_q <= (r_q == BCD_ZERO) ? BCD_MAX : r_q - 4'd1;
    end
  end

  assign o_borrow = i_dec && (r_q == BCD_ZERO);
  assign o_q      = r_q;

endmodule

// File: rtl/bcd_down_timer.sv
// Two-digit BCD down timer with preset, pause/resume, terminal-count pulse
// and optional auto-reload.
module bcd_down_timer #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] d_tens,
  input  logic [3:0] d_ones,
  input  logic       start,
  input  logic       pause,
  input  logic       ce,
  output logic [3:0] q_tens,
  output logic [3:0] q_ones,
  output logic       busy,
  output logic       zero,
  output logic       tc
);
  import bcd_down_timer_pkg::*;

  state_t     r_state;
  bcd2_t      r_preset;
  logic       r_busy;
  logic       r_tc;

  bcd2_t      w_din;
  bcd2_t      w_count;
  bcd2_t      w_load_val;
  logic [3:0] w_q_tens;
  logic [3:0] w_q_ones;
  logic       w_load;
  logic       w_dec;
  logic       w_ones_borrow;
  logic       w_tens_borrow;
  logic       w_zero;
  logic       w_one;
  logic       w_preset_zero;
  logic       w_start_ok;

  assign w_din         = '{tens: bcd_clamp(d_tens), ones: bcd_clamp(d_ones)};
  assign w_count       = '{tens: w_q_tens, ones: w_q_ones};
  assign w_zero        = (w_count == '0);
  assign w_one         = (w_count == '{tens: BCD_ZERO, ones: 4'd1});
  assign w_preset_zero = (r_preset == '0);
  assign w_start_ok    = start && !pause;

  // A decrement at 00 borrows out of the tens digit; that borrow marks the
  // end-of-period tick and is turned into a reload instead of a wrap to 99.
  assign w_dec = !load && (r_state == ST_RUN) && !pause && ce;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = r_preset;
    if (load) begin
      w_load     = 1'b1;
      w_load_val = w_din;
    end else if (w_tens_borrow) begin
      w_load = 1'b1;
      if (!AUTO_RELOAD) w_load_val = '0;
    end else if (r_state == ST_DONE && w_start_ok && !w_preset_zero) begin
      w_load = 1'b1;
    end
  end

  bcd_digit_dn u_ones (
    .clk        (clk),
    .clr        (clr),
    .i_load     (w_load),
    .i_load_val (w_load_val.ones),
    .i_dec      (w_dec),
    .o_q        (w_q_ones),
    .o_borrow   (w_ones_borrow)
  );

  bcd_digit_dn u_tens (
    .clk        (clk),
    .clr        (clr),
    .i_load     (w_load),
    .i_load_val (w_load_val.tens),
    .i_dec      (w_ones_borrow),
    .o_q        (w_q_tens),
    .o_borrow   (w_tens_borrow)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state  <= ST_IDLE;
      r_preset <= '0;
      r_busy   <= 1'b0;
      r_tc     <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (load) begin
        r_preset <= w_din;
        r_state  <= ST_IDLE;
        r_busy   <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_start_ok && !w_zero) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end
          end
          ST_RUN: begin
            if (pause) begin
              r_state <= ST_HOLD;
            end else if (w_tens_borrow) begin
              if (!(AUTO_RELOAD && !w_preset_zero)) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
              end
            end else if (ce && w_one) begin
              r_tc <= 1'b1;
              if (!AUTO_RELOAD) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
              end
            end
          end
          ST_HOLD: begin
            if (w_start_ok) r_state <= ST_RUN;
          end
          ST_DONE: begin
            if (w_start_ok && !w_preset_zero) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign q_tens = w_q_tens;
  assign q_ones = w_q_ones;
  assign busy   = r_busy;
  assign zero   = w_zero;
  assign tc     = r_tc;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Scoreboard bench for bcd_down_timer: a decimal reference model predicts
// {q_tens, q_ones, busy, zero, tc} each cycle; a monitor compares after the edge.
module tb_bcd_down_timer;

  logic       clk = 1'b0;
  logic       clr;
  logic       load, start, pause, ce;
  logic [3:0] d_tens, d_ones;

  logic [3:0] q_tens0, q_ones0, q_tens1, q_ones1;
  logic       busy0, zero0, tc0, busy1, zero1, tc1;

  bcd_down_timer #(.AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .clr(clr), .load(load), .d_tens(d_tens), .d_ones(d_ones),
    .start(start), .pause(pause), .ce(ce),
    .q_tens(q_tens0), .q_ones(q_ones0), .busy(busy0), .zero(zero0), .tc(tc0)
  );

  bcd_down_timer #(.AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .clr(clr), .load(load), .d_tens(d_tens), .d_ones(d_ones),
    .start(start), .pause(pause), .ce(ce),
    .q_tens(q_tens1), .q_ones(q_ones1), .busy(busy1), .zero(zero1), .tc(tc1)
  );

  always #5 clk = ~clk;

  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;
  localparam logic [10:0] RESET_VEC = {4'd0, 4'd0, 1'b0, 1'b1, 1'b0};

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [10:0] sb_q[$];
  bit          sel = 1'b0;
  string       cur_tag = "reset";
  logic [10:0] obs;

  int m_cnt, m_pre, m_st;
  bit m_tc;

  assign obs = sel ? {q_tens1, q_ones1, busy1, zero1, tc1}
                   : {q_tens0, q_ones0, busy0, zero0, tc0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  function automatic logic [10:0] model_vec();
    logic [3:0] t, o;
    t = 4'(m_cnt / 10);
    o = 4'(m_cnt % 10);
    return {t, o, (m_st == M_RUN || m_st == M_HOLD), (m_cnt == 0), m_tc};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_pre = 0; m_st = M_IDLE; m_tc = 1'b0;
  endtask

  task automatic model_step();
    bit go;
    go   = start && !pause;
    m_tc = 1'b0;
    if (load) begin
      m_pre = clamp9(d_tens) * 10 + clamp9(d_ones);
      m_cnt = m_pre;
      m_st  = M_IDLE;
    end else begin
      case (m_st)
        M_IDLE: if (go && m_cnt != 0) m_st = M_RUN;
        M_RUN: begin
          if (pause) m_st = M_HOLD;
          else if (ce) begin
            if (m_cnt == 0) begin
              if (sel && m_pre != 0) m_cnt = m_pre;
              else m_st = M_DONE;
            end else begin
              m_cnt = m_cnt - 1;
              if (m_cnt == 0) begin
                m_tc = 1'b1;
                if (!sel) m_st = M_DONE;
              end
            end
          end
        end
        M_HOLD: if (go) m_st = M_RUN;
        default: if (go && m_pre != 0) begin m_cnt = m_pre; m_st = M_RUN; end
      endcase
    end
  endtask

  task automatic cyc(input bit l, input bit s, input bit p, input bit c,
                     input logic [3:0] dt = 4'd0, input logic [3:0] dd = 4'd0);
    @(negedge clk);
    load = l; start = s; pause = p; ce = c; d_tens = dt; d_ones = dd;
    model_step();
    sb_q.push_back(model_vec());
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) check(cur_tag, obs, sb_q.pop_front());
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr = 1'b0; load = 0; start = 0; pause = 0; ce = 0; d_tens = 0; d_ones = 0;
    model_reset();
    #3;
    check("rst_dut0", {q_tens0, q_ones0, busy0, zero0, tc0}, RESET_VEC);
    check("rst_dut1", {q_tens1, q_ones1, busy1, zero1, tc1}, RESET_VEC);
    @(negedge clk) clr = 1'b1;

    cur_tag = "count23";
    cyc(1, 0, 0, 0, 4'd2, 4'd3);
    cyc(0, 1, 0, 0);
    repeat (25) cyc(0, 0, 0, 1);

    cur_tag = "pause10";
    cyc(1, 0, 0, 0, 4'd1, 4'd0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    repeat (5) cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    repeat (2) cyc(0, 0, 0, 1);

    cur_tag = "clamp_zero";
    cyc(1, 0, 0, 0, 4'hC, 4'hF);
    cyc(1, 0, 0, 0, 4'd0, 4'd0);
    repeat (3) cyc(0, 1, 0, 1);

    cur_tag = "load_prio";
    cyc(1, 0, 0, 0, 4'd4, 4'd8);
    cyc(0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 1);
    cyc(1, 1, 1, 1, 4'd3, 4'd0);
    repeat (2) cyc(0, 0, 0, 1);

    cur_tag = "async_clr";
    cyc(1, 0, 0, 0, 4'd5, 4'd9);
    cyc(0, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 1);
    @(posedge clk);
    #3 clr = 1'b0;
    #1 check("clr_immediate", obs, RESET_VEC);
    model_reset();
    @(negedge clk) clr = 1'b1;
    cur_tag = "after_clr";
    repeat (4) cyc(0, 1, 0, 1);

    @(posedge clk);
    #2 sel = 1'b1;
    clr = 1'b0;
    #1 check("rst_auto", obs, RESET_VEC);
    model_reset();
    @(negedge clk) clr = 1'b1;

    cur_tag = "auto_reload";
    cyc(1, 0, 0, 0, 4'd0, 4'd2);
    cyc(0, 1, 0, 0);
    repeat (8) cyc(0, 0, 0, 1);
    cur_tag = "auto_zero_preset";
    cyc(1, 0, 0, 0, 4'd0, 4'd0);
    repeat (2) cyc(0, 1, 0, 1);

    cyc(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_down_timer.md
BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 Parameter AUTO_RELOAD, default 0, 1 = reload preset and keep running after reaching 00.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 clr  input  1  reset, asynchronous, active-low.
REQ-004 load  input  1  synchronous load of preset digits.
REQ-005 d_tens  input  4  preset tens digit, BCD.
REQ-006 d_ones  input  4  preset ones digit, BCD.
REQ-007 start  input  1  begin or resume counting.
REQ-008 pause  input  1  suspend counting.
REQ-009 ce  input  1  count-enable tick; at most one decrement per cycle with ce=1.
REQ-010 q_tens  output  4  current tens digit, BCD, registered.
REQ-011 q_ones  output  4  current ones digit, BCD, registered.
REQ-012 busy  output  1  high in RUN and HOLD.
REQ-013 zero  output  1  high when q_tens=0 and q_ones=0.
REQ-014 tc  output  1  terminal-count pulse, one cycle.

Function
REQ-015 Count range SHALL be 00..99 BCD; digits never hold values above 9.
REQ-016 States SHALL be IDLE, RUN, HOLD and DONE.
REQ-017 Input priority SHALL be load > pause > start.
REQ-018 load SHALL be honoured in any state: the preset register and the count take {d_tens,d_ones}, and the state becomes IDLE next cycle.
REQ-019 A preset digit above 9 SHALL be clamped to 9 in both the preset register and the count.
REQ-020 IDLE + start with nonzero count -> RUN.
REQ-021 IDLE + start with count 00 -> stay IDLE, tc stays 0.
REQ-022 RUN + ce SHALL decrement once.
REQ-023 Ones 0 -> 9 with tens decremented; otherwise ones decrements and tens holds.
REQ-024 RUN + pause -> HOLD; count is frozen regardless of ce.
REQ-025 HOLD + start (pause low) -> RUN.
REQ-026 The decrement 01 -> 00 SHALL assert tc in the same cycle that q reads 00, for exactly one cycle.
REQ-027 After 01 -> 00 with AUTO_RELOAD=0: state -> DONE.
REQ-028 After 01 -> 00 with AUTO_RELOAD=1: next ce reloads the preset and the state stays RUN.
REQ-029 If the preset is 00 and AUTO_RELOAD=1, the block SHALL go to DONE.
REQ-030 DONE + start SHALL reload the preset and go to RUN when the preset is nonzero; otherwise it stays DONE.
REQ-031 ce, pause and start asserted with no applicable transition SHALL be ignored.
REQ-032 Decrement latency SHALL be one cycle from the ce sample to the updated q.

Reset
REQ-033 clr low SHALL immediately force q_tens=0, q_ones=0, preset register=00, state=IDLE, busy=0, tc=0 and zero=1, independent of clk.
REQ-034 Reset asserted mid-RUN SHALL abort counting; no tc is produced.
REQ-035 After clr rises, the first active edge SHALL behave as IDLE.

Structure
REQ-036 A shared package SHALL hold the state enumeration and the BCD constants (digit max 4'd9, zero 4'd0).
REQ-037 A sub-module bcd_digit_dn SHALL implement one BCD digit with a decrement input, a borrow-out (digit==0 and decrement), and load/clamp.
REQ-038 bcd_digit_dn SHALL be instantiated twice, with the ones borrow-out driving the tens decrement.
REQ-039 The control FSM SHALL reside in bcd_down_timer.

Verification
REQ-040 Load 23, start, ce held high -> q steps 23,22,21,20,19 ... 01,00; tc high only at 00; state DONE, busy=0.
REQ-041 Load 10, start, pause after 1 tick -> q holds 09 for 5 cycles with ce=1; start -> resumes 08.
REQ-042 AUTO_RELOAD=1, load 02, start, ce high -> q 02,01,00(tc),02,01,00(tc); busy stays 1.
REQ-043 Load with d_tens=4'hC, d_ones=4'hF -> q=99; load of 00 then start -> stays IDLE, tc=0.
REQ-044 Simultaneous load=1, pause=1, start=1 during RUN at q=45 with d=30 -> q=30, state IDLE.
REQ-045 clr asserted between clock edges mid-RUN at q=57 -> q=00, zero=1, busy=0 immediately; no tc afterward without a new load and start.
